// File: rtl/vr16_pkg.sv
// Shared definitions for the VR16 control path: opcodes, instruction field positions,
// write-data select encoding and sequencer state encoding.
package vr16_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned RA_MSB   = 7;
  localparam int unsigned RA_LSB   = 4;
  localparam int unsigned RB_MSB   = 3;
  localparam int unsigned RB_LSB   = 0;
  localparam int unsigned ADDR_MSB = 7;
  localparam int unsigned ADDR_LSB = 0;

  localparam logic WSEL_ALU = 1'b0;
  localparam logic WSEL_MEM = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalted
  } cu_state_e;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decoder: splits IR into fields and classifies the opcode.
module cu_decode
  import vr16_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  op,
  output logic [3:0]  rd,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [7:0]  addr,
  output logic        is_alu,
  output logic        is_load,
  output logic        is_store,
  output logic        is_jump,
  output logic        is_halt
);

  assign op   = ir[OP_MSB:OP_LSB];
  assign rd   = ir[RD_MSB:RD_LSB];
  assign ra   = ir[RA_MSB:RA_LSB];
  assign rb   = ir[RB_MSB:RB_LSB];
  assign addr = ir[ADDR_MSB:ADDR_LSB];

  // Anything the sequencer does not execute itself belongs to the ALU.
  always_comb begin
    is_alu   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_jump  = 1'b0;
    is_halt  = 1'b0;
    unique case (op)
      OP_LOAD:  is_load  = 1'b1;
      OP_STORE: is_store = 1'b1;
      OP_JUMP:  is_jump  = 1'b1;
      OP_HALT:  is_halt  = 1'b1;
      default:  is_alu   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// VR16 multi-cycle sequencer: fetch, decode, then drive ALU, register file and data
// memory one instruction at a time. All outputs are decoded from state and IR (Moore).
module control_unit
  import vr16_pkg::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [15:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [3:0]       rf_ra,
  output logic [3:0]       rf_rb,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic             rf_wsel,
  output logic             alu_enable,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_imm,
  output logic [PC_W-1:0]  dmem_addr,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  cu_state_e        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] op, rd, ra, rb;
  logic [7:0] addr;
  logic       is_alu, is_load, is_store, is_jump, is_halt;

  cu_decode u_decode (
    .ir       (ir_q),
    .op       (op),
    .rd       (rd),
    .ra       (ra),
    .rb       (rb),
    .addr     (addr),
    .is_alu   (is_alu),
    .is_load  (is_load),
    .is_store (is_store),
    .is_jump  (is_jump),
    .is_halt  (is_halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_alu) begin
          state_d = StExec;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else if (is_jump) begin
          pc_d      = PC_W'(addr);
          retired_d = retired_q + CNT_W'(1);
          state_d   = StFetch;
        end else if (is_halt) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = StHalted;
        end
      end
      StExec: state_d = StWb;
      StMem: begin
        // STORE completes here; LOAD still needs its write-back cycle.
        if (is_store) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StWb: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = StFetch;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rf_ra      = '0;
    rf_rb      = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wsel    = WSEL_ALU;
    alu_enable = 1'b0;
    alu_opcode = '0;
    alu_imm    = '0;
    dmem_addr  = '0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    busy       = 1'b1;
    halted     = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StFetch: ;
      StDecode: begin
        rf_ra = ra;
        rf_rb = rb;
      end
      StExec: begin
        rf_ra      = ra;
        rf_rb      = rb;
        alu_enable = 1'b1;
        alu_opcode = op;
        alu_imm    = rb;
      end
      StMem: begin
        dmem_addr = PC_W'(addr);
        if (is_store) begin
          dmem_we = 1'b1;
          rf_ra   = rd;
        end else begin
          dmem_re = 1'b1;
        end
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        rf_wsel  = is_load ? WSEL_MEM : WSEL_ALU;
      end
      StHalted: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: walks each instruction class cycle by cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [3:0]  rf_ra, rf_rb, rf_waddr, alu_opcode, alu_imm;
  logic        rf_we, rf_wsel, alu_enable, dmem_re, dmem_we, busy, halted;
  logic [7:0]  dmem_addr;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit #(.PC_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .rf_ra      (rf_ra),
    .rf_rb      (rf_rb),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wsel    (rf_wsel),
    .alu_enable (alu_enable),
    .alu_opcode (alu_opcode),
    .alu_imm    (alu_imm),
    .dmem_addr  (dmem_addr),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset, then start; leaves the DUT in FETCH at pc 0.
  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; imem_valid = 1'b0; imem_rdata = 16'h0;
    tick(); tick();
    n_checks++;
    if ({busy, halted, rf_we, alu_enable, dmem_re, dmem_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {busy, halted, rf_we, alu_enable, dmem_re, dmem_we});
    end
    n_checks++;
    if ({imem_addr, dmem_addr, retired, rf_ra, rf_rb, rf_waddr, alu_opcode, alu_imm, rf_wsel}
        !== 53'h0) begin
      n_fail++;
      $display("FAIL reset_buses: imem_addr=%h dmem_addr=%h retired=%h, expected all 0",
               imem_addr, dmem_addr, retired);
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b expected 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL fetch_entry: busy=%b imem_addr=%h expected 1/00", busy, imem_addr);
    end
  endtask

  task automatic test_alu();
    imem_rdata = 16'h0312; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    n_checks++;
    if (rf_ra !== 4'd1 || rf_rb !== 4'd2 || alu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_decode: ra=%0d rb=%0d en=%b expected 1/2/0", rf_ra, rf_rb, alu_enable);
    end
    tick();
    n_checks++;
    if (alu_enable !== 1'b1 || alu_opcode !== 4'h0 || alu_imm !== 4'h2 || rf_ra !== 4'd1
        || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_exec: en=%b op=%h imm=%h ra=%0d we=%b expected 1/0/2/1/0",
               alu_enable, alu_opcode, alu_imm, rf_ra, rf_we);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wsel !== 1'b0 || alu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_wb: we=%b waddr=%0d wsel=%b en=%b expected 1/3/0/0",
               rf_we, rf_waddr, rf_wsel, alu_enable);
    end
    tick();
    n_checks++;
    if (retired !== 16'd1 || imem_addr !== 8'h01 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_retire: retired=%0d imem_addr=%h we=%b expected 1/01/0",
               retired, imem_addr, rf_we);
    end
  endtask

  task automatic test_load_store();
    imem_rdata = 16'h8540; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    n_checks++;
    if (dmem_re !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'h40 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_mem: re=%b we=%b addr=%h rf_we=%b expected 1/0/40/0",
               dmem_re, dmem_we, dmem_addr, rf_we);
    end
    tick();
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd5 || rf_wsel !== 1'b1 || dmem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wb: we=%b waddr=%0d wsel=%b re=%b expected 1/5/1/0",
               rf_we, rf_waddr, rf_wsel, dmem_re);
    end
    tick();
    n_checks++;
    if (retired !== 16'd2 || imem_addr !== 8'h02) begin
      n_fail++;
      $display("FAIL load_retire: retired=%0d imem_addr=%h expected 2/02", retired, imem_addr);
    end
    imem_rdata = 16'hA640; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    n_checks++;
    if (dmem_we !== 1'b1 || dmem_re !== 1'b0 || dmem_addr !== 8'h40 || rf_ra !== 4'd6) begin
      n_fail++;
      $display("FAIL store_mem: we=%b re=%b addr=%h ra=%0d expected 1/0/40/6",
               dmem_we, dmem_re, dmem_addr, rf_ra);
    end
    tick();
    n_checks++;
    if (retired !== 16'd3 || imem_addr !== 8'h03 || dmem_we !== 1'b0 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL store_retire: retired=%0d imem_addr=%h dmem_we=%b rf_we=%b exp 3/03/0/0",
               retired, imem_addr, dmem_we, rf_we);
    end
  endtask

  task automatic test_jump_wrap();
    restart();
    imem_rdata = 16'h90FF; imem_valid = 1'b1;
    tick();
    imem_rdata = 16'h0312;
    tick();
    n_checks++;
    if (imem_addr !== 8'hFF || retired !== 16'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_target: imem_addr=%h retired=%0d busy=%b expected ff/1/1",
               imem_addr, retired, busy);
    end
    tick();
    imem_valid = 1'b0;
    n_checks++;
    if (imem_addr !== 8'h00 || rf_ra !== 4'd1) begin
      n_fail++;
      $display("FAIL pc_wrap: imem_addr=%h ra=%0d expected 00/1", imem_addr, rf_ra);
    end
    tick(); tick(); tick();
    n_checks++;
    if (imem_addr !== 8'h00 || retired !== 16'd2) begin
      n_fail++;
      $display("FAIL wrap_retire: imem_addr=%h retired=%0d expected 00/2", imem_addr, retired);
    end
  endtask

  task automatic test_stall_halt();
    imem_valid = 1'b0; imem_rdata = 16'hF000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b1 || imem_addr !== 8'h00 || rf_ra !== 4'd0) begin
        n_fail++;
        $display("FAIL stall_%0d: busy=%b imem_addr=%h ra=%0d expected 1/00/0",
                 i, busy, imem_addr, rf_ra);
      end
    end
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    n_checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || retired !== 16'd3) begin
      n_fail++;
      $display("FAIL halt_enter: halted=%b busy=%b retired=%0d expected 1/0/3",
               halted, busy, retired);
    end
    start = 1'b1; imem_valid = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    imem_valid = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || retired !== 16'd3 || imem_addr !== 8'h01) begin
      n_fail++;
      $display("FAIL halt_sticky: halted=%b busy=%b retired=%0d imem_addr=%h exp 1/0/3/01",
               halted, busy, retired, imem_addr);
    end
  endtask

  task automatic test_reset_exec();
    restart();
    imem_rdata = 16'h0312; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    n_checks++;
    if (alu_enable !== 1'b1) begin
      n_fail++; $display("FAIL rst_exec_pre: alu_enable=%b expected 1", alu_enable);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (alu_enable !== 1'b0 || rf_we !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_exec_drop: en=%b we=%b busy=%b imem_addr=%h expected 0/0/0/00",
               alu_enable, rf_we, busy, imem_addr);
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (rf_we !== 1'b0 || retired !== 16'd0 || busy !== 1'b0 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_exec_no_wb: we=%b retired=%0d busy=%b imem_addr=%h expected 0/0/0/00",
               rf_we, retired, busy, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_jump_wrap();
    test_stall_halt();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer for the VR16 core: fetches 16-bit instructions, decodes them, and drives the register file, the registered ALU, and data memory.
- Executes LOAD, JUMP, STORE and HALT itself; hands every other opcode to the ALU.
- Sits between instruction memory, register file, ALU and data memory.
- Exactly one instruction is in flight at a time; there is no pipelining.

Parameters:
- PC_W, 8, program-counter and memory-address width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching from pc
- imem_addr  out  PC_W  instruction address (equals pc)
- imem_rdata  in  16  instruction word
- imem_valid  in  1  imem_rdata valid this cycle
- rf_ra  out  4  register-file read port A address
- rf_rb  out  4  register-file read port B address
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  register-file write address
- rf_wsel  out  1  write-data select: 0 = ALU result, 1 = dmem read data
- alu_enable  out  1  one-cycle ALU strobe
- alu_opcode  out  4  ALU opcode
- alu_imm  out  4  ALU immediate
- dmem_addr  out  PC_W  data-memory address
- dmem_re  out  1  data-memory read strobe
- dmem_we  out  1  data-memory write strobe
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, port name reset.
- Instruction format: IR[15:12] = op, IR[11:8] = rd/rs, IR[7:4] = ra, IR[3:0] = rb/imm, IR[7:0] = addr8.
- Reset clears pc, IR and retired to 0 and sets state to IDLE. All strobes are 0 and every output is 0 during and after reset.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED. All outputs are decoded from registered state and IR only (Moore).
- IDLE:
  - start = 1 -> FETCH.
  - start is ignored in every other state.
- FETCH:
  - imem_addr = pc.
  - Stays in FETCH while imem_valid = 0.
  - On imem_valid = 1: IR <= imem_rdata, pc <= pc + 1 (wraps 255 -> 0), -> DECODE.
- DECODE:
  - rf_ra = IR[7:4], rf_rb = IR[3:0].
  - op 0-7 or B-E -> EXEC.
  - op 8 (LOAD) -> MEM.
  - op A (STORE) -> MEM.
  - op 9 (JUMP): pc <= IR[7:0], retired++, -> FETCH.
  - op F (HALT): retired++, -> HALTED.
- EXEC:
  - alu_enable = 1 for exactly one cycle; alu_opcode = IR[15:12], alu_imm = IR[3:0].
  - rf_ra/rf_rb are held at the DECODE values.
  - -> WB.
- MEM, LOAD:
  - dmem_re = 1, dmem_addr = IR[7:0].
  - Read data is valid the next cycle.
  - -> WB.
- MEM, STORE:
  - dmem_we = 1, dmem_addr = IR[7:0], rf_ra = IR[11:8] (the data source).
  - retired++, -> FETCH.
- WB:
  - rf_we = 1, rf_waddr = IR[11:8]; rf_wsel = 0 for ALU ops, 1 for LOAD.
  - retired++, -> FETCH.
- HALTED: absorbing state; only reset leaves it. busy = 0, halted = 1.
- Minimum latencies with imem_valid = 1 on the first FETCH cycle: ALU op 4 cycles, LOAD 4, STORE 3, JUMP 2, HALT 2 (to HALTED).
- retired wraps at 2^CNT_W - 1 -> 0.
- Reset asserted mid-instruction (any state): immediate return to IDLE. Partial writes are dropped and no strobe is emitted after reset asserts.
- At most one of rf_we, dmem_we, dmem_re and alu_enable is high in any cycle.

Decomposition:
- vr16_pkg holds:
  - opcode localparams: OP_ADD..OP_XOR, OP_LOAD = 4'h8, OP_JUMP = 4'h9, OP_STORE = 4'hA, OP_HALT = 4'hF;
  - state encoding;
  - WSEL_ALU / WSEL_MEM;
  - instruction field bit positions.
- One combinational sub-module, cu_decode: takes IR and outputs is_alu, is_load, is_store, is_jump, is_halt and the field slices.
- The FSM, pc and counter stay in control_unit.

Test Plan:
- Reset: hold reset with start = 1 -> all outputs 0, state IDLE. Release reset; start pulse -> FETCH with imem_addr = 0.
- ALU op: IR = 16'h0312 (ADD r3 = r1 + r2), imem_valid immediate -> DECODE rf_ra = 1 / rf_rb = 2; EXEC alu_enable = 1, alu_opcode = 0; WB rf_we = 1, rf_waddr = 3, rf_wsel = 0; retired = 1; next imem_addr = 1.
- LOAD / STORE: IR = 16'h8540 -> MEM dmem_re = 1 / dmem_addr = 8'h40, then WB rf_waddr = 5 / rf_wsel = 1. IR = 16'hA640 -> dmem_we = 1, rf_ra = 6, back to FETCH after 3 cycles.
- JUMP and PC wrap: JUMP at pc = 0 to 8'hFF -> next fetch at 0xFF. Its successor increments pc to 0x00; no wrap glitch.
- Fetch stall and HALT: hold imem_valid = 0 for 5 cycles -> remains in FETCH with imem_addr stable. Then IR = 16'hF000 -> halted = 1, busy = 0. start pulses are ignored; retired stays unchanged.
- Reset during EXEC: assert reset in the EXEC cycle -> alu_enable and rf_we drop the same cycle, no WB occurs, pc = 0.
